// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
//   Groups the key/carry inputs and the control outputs of the stopwatch
//   controller.
//   master : key source / counter datapath side. Drives key_ss, key_lc and
//            chain_carry. Observes tick_en, cnt_clr, freeze, ovf and state.
//   slave  : the controller itself.
//
//   key_ss      start/stop pulse, one clk wide, debounced
//   key_lc      lap/clear pulse, one clk wide, debounced
//   chain_carry carry from the last decade stage (999999 -> 000000)
//   tick_en     one-clk count enable to the first decade stage
//   cnt_clr     one-clk synchronous clear to all decade stages
//   freeze      display-hold strobe, high while a lap snapshot is shown
//   ovf         high while the stopwatch has overflowed
//   state       IDLE=0, RUN=1, PAUSE=2, LAP=3, OVF=4
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic       key_ss;
  logic       key_lc;
  logic       chain_carry;
  logic       tick_en;
  logic       cnt_clr;
  logic       freeze;
  logic       ovf;
  logic [2:0] state;

  modport master (
    output key_ss, key_lc, chain_carry,
    input  tick_en, cnt_clr, freeze, ovf, state
  );

  modport slave (
    input  key_ss, key_lc, chain_carry,
    output tick_en, cnt_clr, freeze, ovf, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/lap/clear controller for a 6-digit cascaded decade counter.
//   Owns the tick divider, drives the first stage count enable and the
//   synchronous clear of all stages, holds the display during a lap and
//   flags overflow from the last-stage carry.
//
//   Parameters
//     TICK_DIV  clk cycles per count tick (2 .. 2^32-1)
//     DIV_W     divider width, TICK_DIV-1 must fit
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   stopwatch_ctrl_if.slave (keys and carry in, controls out)
//
//   All outputs are registered. Event priority within a cycle is
//   chain_carry > key_ss > key_lc; an event that is not the winner is
//   dropped. Events with no meaning in the current state are ignored.
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned DIV_W    = 32
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_OVF   = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick_en;
  logic             r_cnt_clr;
  logic             r_freeze;
  logic             r_ovf;
  logic             w_tick_due;

  assign w_tick_due = (r_div_cnt == DIV_MAX);

  // NOTE: every register here, including the divider, gets an explicit reset
  // value and is updated with non-blocking assignments only, so each branch
  // below reads the pre-edge values no matter in which order it is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_tick_en <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_freeze  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // Both strobes are single-cycle; they default low every edge.
      r_tick_en <= 1'b0;
      r_cnt_clr <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          if (bus.key_ss) begin
            r_state <= S_RUN;
          end
        end

        S_RUN, S_LAP: begin
          if (bus.chain_carry) begin
            // Counting stops; the counters hold 000000 until cleared.
            r_state   <= S_OVF;
            r_div_cnt <= '0;
            r_freeze  <= 1'b0;
            r_ovf     <= 1'b1;
          end else if (bus.key_ss) begin
            r_state  <= S_PAUSE;
            r_freeze <= 1'b0;
            // A tick due on the pause edge is still issued; otherwise the
            // sub-tick phase is frozen where it stands.
            if (w_tick_due) begin
              r_tick_en <= 1'b1;
              r_div_cnt <= '0;
            end
          end else begin
            r_tick_en <= w_tick_due;
            r_div_cnt <= w_tick_due ? '0 : r_div_cnt + DIV_W'(1);
            if (bus.key_lc) begin
              r_state  <= (r_state == S_RUN) ? S_LAP : S_RUN;
              r_freeze <= (r_state == S_RUN);
            end
          end
        end

        S_PAUSE: begin
          if (bus.key_ss) begin
            // Resume keeps r_div_cnt, so the partial tick is not lost.
            r_state <= S_RUN;
          end else if (bus.key_lc) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_cnt_clr <= 1'b1;
          end
        end

        S_OVF: begin
          r_div_cnt <= '0;
          if (bus.key_lc) begin
            r_state   <= S_IDLE;
            r_ovf     <= 1'b0;
            r_cnt_clr <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_div_cnt <= '0;
          r_freeze  <= 1'b0;
          r_ovf     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick_en = r_tick_en;
  assign bus.cnt_clr = r_cnt_clr;
  assign bus.freeze  = r_freeze;
  assign bus.ovf     = r_ovf;
  assign bus.state   = r_state;

endmodule
